// File: rtl/iob_sync_handshake_tx.sv
// Source side of a four-phase req/ack crossing: holds a captured word on data_o,
// raises req_o, and waits for the synchronized ack through both phases.
module iob_sync_handshake_tx #(
   parameter int                DATA_W      = 21,
   parameter logic [DATA_W-1:0] RST_VAL     = '0,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] data_o,
   output logic              req_o,
   input  logic              ack_i,
   output logic              done_o,
   output logic              busy_o,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic [DATA_W-1:0]      data_d;
   logic                   req_d;
   logic                   done_d;

   // ack_i is asynchronous to clk_i; only the last stage is ever looked at.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   // Local handshake: a word transfers on a rising edge where valid_i && ready_o.
   // valid_i may stay high; ready_o drops right after the accept and only returns
   // once the remote side has fully returned ack to zero.
   assign ready_o     = (state_q == IDLE) && !ack_s;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_o;
      req_d   = req_o;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            req_d = 1'b0;
            if (valid_i && ready_o) begin
               data_d  = data_i;
               state_d = SETUP;
            end
         end
         SETUP: begin
            // data_o was loaded last edge, so it is stable before req_o rises.
            req_d   = 1'b1;
            state_d = REQ;
         end
         REQ: begin
            req_d = 1'b1;
            if (ack_s) begin
               req_d   = 1'b0;
               done_d  = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            req_d = 1'b0;
            if (!ack_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
         data_o  <= RST_VAL;
         req_o   <= 1'b0;
         done_o  <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_o  <= data_d;
         req_o   <= req_d;
         done_o  <= done_d;
         busy_o  <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_iob_sync_handshake_tx.sv
// Directed bench for iob_sync_handshake_tx: loopback, back-to-back, slow receiver,
// stale ack and mid-transfer reset, with a scoreboard on done_o.
module tb_iob_sync_handshake_tx;

   localparam int DATA_W = 21;

   logic              clk_i;
   logic              arst_n_i;
   logic [DATA_W-1:0] data_i;
   logic              valid_i;
   logic              ready_o;
   logic [DATA_W-1:0] data_o;
   logic              req_o;
   logic              ack_i;
   logic              done_o;
   logic              busy_o;
   logic [1:0]        dbg_state_o;

   logic              loopback;
   logic              ack_man;

   int                checks   = 0;
   int                failures = 0;
   int                done_cnt = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic              prev_req = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   assign ack_i = loopback ? req_o : ack_man;

   iob_sync_handshake_tx #(
      .DATA_W      (DATA_W),
      .RST_VAL     ('0),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_o      (data_o),
      .req_o       (req_o),
      .ack_i       (ack_i),
      .done_o      (done_o),
      .busy_o      (busy_o),
      .dbg_state_o (dbg_state_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      bit seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         tick();
         if (done_o) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      bit idle = 1'b0;
      for (int i = 0; i < max_cycles && !idle; i++) begin
         tick();
         if (ready_o && !busy_o) idle = 1'b1;
      end
      check(tag, 32'(idle), 32'd1);
   endtask

   // scoreboard and stability monitor, sampled mid-cycle
   always @(negedge clk_i) begin
      if (!arst_n_i) begin
         prev_req = 1'b0;
      end else begin
         if (done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) check("sb_unexpected_done", 32'd1, 32'd0);
            else check("sb_data", 32'(data_o), 32'(exp_q.pop_front()));
            check("done_req_low", 32'(req_o), 32'd0);
         end
         if (prev_req && req_o) check("data_stable_req", 32'(data_o), 32'(prev_data));
         if (!busy_o) check("done_not_idle", 32'(done_o), 32'd0);
         prev_req  = req_o;
         prev_data = data_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      arst_n_i = 1'b0;
      data_i   = '0;
      valid_i  = 1'b0;
      loopback = 1'b0;
      ack_man  = 1'b0;

      // 1: reset values
      repeat (3) tick();
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_req", 32'(req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_state", 32'(dbg_state_o), 32'd0);
      @(negedge clk_i);
      arst_n_i = 1'b1;
      tick();

      // 2: single word over loopback, cycle-by-cycle
      loopback = 1'b1;
      data_i   = 21'h1ABCD;
      valid_i  = 1'b1;
      check("t2_ready_pre", 32'(ready_o), 32'd1);
      tick();                                   // accept edge
      exp_q.push_back(21'h1ABCD);
      valid_i = 1'b0;
      check("t2_data", 32'(data_o), 32'h1ABCD);
      check("t2_req_setup", 32'(req_o), 32'd0);
      check("t2_busy", 32'(busy_o), 32'd1);
      check("t2_ready_busy", 32'(ready_o), 32'd0);
      tick();
      check("t2_req_high", 32'(req_o), 32'd1);
      tick();
      check("t2_done_early1", 32'(done_o), 32'd0);
      tick();
      check("t2_done_early2", 32'(done_o), 32'd0);
      tick();                                   // 3 edges after req_o rose
      check("t2_done", 32'(done_o), 32'd1);
      check("t2_req_low", 32'(req_o), 32'd0);
      tick();
      check("t2_done_pulse", 32'(done_o), 32'd0);
      check("t2_ready_rel1", 32'(ready_o), 32'd0);
      tick();
      check("t2_ready_rel2", 32'(ready_o), 32'd0);
      tick();                                   // 7 edges after accept
      check("t2_ready_back", 32'(ready_o), 32'd1);
      check("t2_busy_back", 32'(busy_o), 32'd0);
      check("t2_data_hold", 32'(data_o), 32'h1ABCD);

      // 3: valid_i held high; ready returns 7 edges after accept, next accept on the following edge
      data_i  = 21'd1;
      valid_i = 1'b1;
      tick();
      check("t3_w1", 32'(data_o), 32'd1);
      exp_q.push_back(21'd1);
      data_i = 21'd2;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("t3_hold1", 32'(data_o), 32'd1);
      end
      tick();
      check("t3_w2", 32'(data_o), 32'd2);
      exp_q.push_back(21'd2);
      data_i = 21'd3;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("t3_hold2", 32'(data_o), 32'd2);
      end
      tick();
      check("t3_w3", 32'(data_o), 32'd3);
      exp_q.push_back(21'd3);
      valid_i = 1'b0;
      data_i  = 21'h1FFFF;
      wait_idle("t3_idle", 20);
      check("t3_data_final", 32'(data_o), 32'd3);

      // 4: slow receiver, ack 20 cycles after req
      loopback = 1'b0;
      ack_man  = 1'b0;
      data_i   = 21'h0F00F;
      valid_i  = 1'b1;
      tick();
      exp_q.push_back(21'h0F00F);
      valid_i = 1'b0;
      tick();
      check("t4_req_up", 32'(req_o), 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t4_req_hold", 32'(req_o), 32'd1);
         check("t4_data_hold", 32'(data_o), 32'h0F00F);
      end
      ack_man = 1'b1;
      wait_done("t4_done", 6);
      check("t4_req_dropped", 32'(req_o), 32'd0);
      repeat (4) tick();
      check("t4_release_busy", 32'(busy_o), 32'd1);
      check("t4_release_ready", 32'(ready_o), 32'd0);
      ack_man = 1'b0;
      wait_idle("t4_idle", 6);

      // 5: stale ack out of reset
      ack_man  = 1'b1;
      arst_n_i = 1'b0;
      tick();
      @(negedge clk_i);
      arst_n_i = 1'b1;
      tick();
      tick();                                   // ack_s now 1
      data_i  = 21'h155AA;
      valid_i = 1'b1;
      check("t5_ready_stale", 32'(ready_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_no_accept", 32'(busy_o), 32'd0);
         check("t5_no_req", 32'(req_o), 32'd0);
         check("t5_data_rst", 32'(data_o), 32'd0);
      end
      ack_man = 1'b0;
      tick();
      check("t5_ready_e1", 32'(ready_o), 32'd0);
      tick();
      check("t5_ready_e2", 32'(ready_o), 32'd1);
      check("t5_data_pre", 32'(data_o), 32'd0);
      tick();
      check("t5_accept", 32'(data_o), 32'h155AA);
      exp_q.push_back(21'h155AA);
      valid_i  = 1'b0;
      loopback = 1'b1;
      wait_done("t5_done", 8);
      wait_idle("t5_idle", 8);

      // 6: reset in REQ with ack still high
      loopback = 1'b0;
      ack_man  = 1'b0;
      data_i   = 21'h0DEAD;
      valid_i  = 1'b1;
      tick();
      exp_q.push_back(21'h0DEAD);
      valid_i = 1'b0;
      tick();
      check("t6_req_up", 32'(req_o), 32'd1);
      ack_man = 1'b1;
      tick();
      #2;
      arst_n_i = 1'b0;
      #1;
      check("t6_async_req", 32'(req_o), 32'd0);
      check("t6_async_data", 32'(data_o), 32'd0);
      check("t6_async_busy", 32'(busy_o), 32'd0);
      exp_q.delete();                           // aborted transfer never completes
      @(posedge clk_i);
      @(negedge clk_i);
      arst_n_i = 1'b1;
      tick();
      tick();
      data_i  = 21'h0BEEF;
      valid_i = 1'b1;
      check("t6_ready_stale", 32'(ready_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_accept", 32'(busy_o), 32'd0);
         check("t6_data_rst", 32'(data_o), 32'd0);
      end
      ack_man = 1'b0;
      tick();
      tick();
      check("t6_ready_back", 32'(ready_o), 32'd1);
      tick();
      check("t6_accept", 32'(data_o), 32'h0BEEF);
      exp_q.push_back(21'h0BEEF);
      valid_i  = 1'b0;
      loopback = 1'b1;
      wait_done("t6_done", 8);
      wait_idle("t6_idle", 8);

      // final report
      repeat (2) tick();
      check("done_count", 32'(done_cnt), 32'd7);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
